dev_port_arb: RTL and testbench
===============================

# dev_port_arb

Round-robin arbiter sharing one Ibex device-side memory port among NUM_REQ requesters, e.g. the Ibex LSU plus a debug/DMA agent, in front of the AXI-Lite bridge. It keeps at most one transaction outstanding downstream and routes grant, completion, read data and error back to the owning requester. Upstream and downstream ports both use the same protocol: req held until gnt, then a single-cycle rvalid completion.

## Interface
- NUM_REQ, 2, number of upstream requesters (2..8)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- up_req_i  in  NUM_REQ  per-requester request; held until its gnt
- up_addr_i  in  NUM_REQ*32  flattened word addresses, requester i at [32i+:32]
- up_we_i  in  NUM_REQ  write enable
- up_be_i  in  NUM_REQ*4  byte enables
- up_wdata_i  in  NUM_REQ*32  write data
- up_gnt_o  out  NUM_REQ  one-hot grant pulse
- up_rvalid_o  out  NUM_REQ  one-hot completion pulse
- up_err_o  out  1  error, valid with any up_rvalid_o bit
- up_rdata_o  out  32  read data, valid with any up_rvalid_o bit
- dn_req_o, dn_addr_o[31:0], dn_we_o, dn_be_o[3:0], dn_wdata_o[31:0]  out  downstream request
- dn_gnt_i, dn_rvalid_i, dn_err_i, dn_rdata_i[31:0]  in  downstream response

## Operation
- States:
  - S_ARB: no lock. Winner is the first requester with up_req_i set, scanning from rr_ptr upward mod NUM_REQ.
  - S_HOLD: winner locked, waiting for dn_gnt_i.
  - S_WAIT: granted, waiting for dn_rvalid_i.
- S_ARB, any up_req_i:
  - Drive dn_* from the winner, combinationally.
  - If dn_gnt_i is high the same cycle: up_gnt_o[winner]=1, owner<=winner, go to S_WAIT.
  - Otherwise: owner<=winner, go to S_HOLD.
- S_HOLD:
  - dn_* driven from owner; owner does not change.
  - On dn_gnt_i: up_gnt_o[owner]=1, go to S_WAIT.
- S_WAIT:
  - dn_req_o=0.
  - On dn_rvalid_i: up_rvalid_o[owner]=1; up_rdata_o=dn_rdata_i and up_err_o=dn_err_i, both combinational pass-through.
  - Same cycle: rr_ptr<=(owner+1) mod NUM_REQ, go to S_ARB.
- dn_gnt_i outside S_ARB/S_HOLD, or dn_rvalid_i outside S_WAIT: ignored. Sticky status bit proto_err_q is set; it is reset-only and observable hierarchically by the bench.
- Requests are not reordered. A requester that drops req before its gnt (protocol violation) while locked in S_HOLD still has dn_req_o held, driven from the stored owner.

## Timing
- Reset values:
  - up_gnt_o=0, up_rvalid_o=0, up_err_o=0, up_rdata_o=0
  - dn_req_o=0 and all dn_* data outputs 0
  - state=S_ARB, rr_ptr=0, owner=0
- Latency: zero-cycle request pass-through in S_ARB. Grant is combinational with dn_gnt_i. Completion is combinational with dn_rvalid_i.
- Minimum spacing between downstream grants is 2 cycles: grant, then rvalid, then a new arbitration in the cycle after rvalid.
- Outside rvalid cycles, up_rdata_o and up_err_o are 0.
- Reset mid-transaction: asynchronous return to S_ARB. Any late dn_rvalid_i is flagged in proto_err_q; it is not forwarded.

## Configuration
- DEV_PORT_ARB_FIXED_PRIO_EN defined: rr_ptr is tied to 0, so requester 0 has the highest priority and lowest index wins.
- Undefined (default): round-robin as above.
- Both builds keep the S_HOLD lock.

## Test plan
- Single requester: req0 read 0x1000, dn_gnt_i same cycle, dn_rvalid_i 3 cycles later with rdata 0xDEADBEEF.
  - Required: up_gnt_o=01, then up_rvalid_o=01 with rdata 0xDEADBEEF, err=0.
- Both requesting continuously, immediate gnt, rvalid 1 cycle after gnt.
  - Required: grants alternate 01,10,01,10 (round-robin).
  - With DEV_PORT_ARB_FIXED_PRIO_EN: always 01.
- Downstream stalls gnt for 4 cycles while req1 is held and req0 rises.
  - Required: dn_addr_o stays at req1's address throughout; the gnt goes to req1.
- Write from req1, be=0x3, wdata=0x12345678, dn_err_i=1 on rvalid.
  - Required: dn_be_o=0x3 and dn_wdata_o=0x12345678 during the request.
  - Required: up_rvalid_o=10 with up_err_o=1.
- Spurious dn_rvalid_i in S_ARB.
  - Required: no up_rvalid_o; proto_err_q=1.
- Assert rst_n low while in S_WAIT.
  - Required: all outputs 0 immediately.
  - Required: after release, the next request is granted normally with rr_ptr=0.

Source files
------------

// File: rtl/dev_port_arb.sv
// dev_port_arb: round-robin arbiter sharing one Ibex-style device memory port
// among NUM_REQ requesters. At most one transaction is outstanding downstream.
// Grant, completion, read data and error are routed back to the owning requester.
//
// Build option: define DEV_PORT_ARB_FIXED_PRIO_EN to tie the round-robin
// pointer to 0 (fixed priority, lowest index wins). The lock held while
// waiting for the downstream grant is kept in both builds.
module dev_port_arb #(
  parameter int NUM_REQ = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    up_req_i,
  input  logic [NUM_REQ*32-1:0] up_addr_i,
  input  logic [NUM_REQ-1:0]    up_we_i,
  input  logic [NUM_REQ*4-1:0]  up_be_i,
  input  logic [NUM_REQ*32-1:0] up_wdata_i,
  output logic [NUM_REQ-1:0]    up_gnt_o,
  output logic [NUM_REQ-1:0]    up_rvalid_o,
  output logic                  up_err_o,
  output logic [31:0]           up_rdata_o,
  output logic                  dn_req_o,
  output logic [31:0]           dn_addr_o,
  output logic                  dn_we_o,
  output logic [3:0]            dn_be_o,
  output logic [31:0]           dn_wdata_o,
  input  logic                  dn_gnt_i,
  input  logic                  dn_rvalid_i,
  input  logic                  dn_err_i,
  input  logic [31:0]           dn_rdata_i
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_ARB  = 2'd0,  // no lock, pick a winner this cycle
    S_HOLD = 2'd1,  // winner locked, waiting for downstream grant
    S_WAIT = 2'd2   // granted, waiting for downstream completion
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             proto_err_q, proto_err_d;

  logic [PTR_W-1:0] win_idx;
  logic             win_found;
  logic [PTR_W-1:0] cand;
  logic [PTR_W-1:0] sel;

  // Round-robin search: first requesting index at or above rr_ptr, wrapping.
  // NOTE: every variable written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    // Scan from the farthest offset down so the nearest requester is written last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (up_req_i[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  // Next-state logic and all upstream/downstream handshake outputs.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    proto_err_d = proto_err_q;
    sel         = owner_q;
    dn_req_o    = 1'b0;
    up_gnt_o    = '0;
    up_rvalid_o = '0;
    up_rdata_o  = '0;
    up_err_o    = 1'b0;

    case (state_q)
      S_ARB: begin
        if (win_found) begin
          sel      = win_idx;
          dn_req_o = 1'b1;
          owner_d  = win_idx;
          if (dn_gnt_i) begin
            up_gnt_o[win_idx] = 1'b1;
            state_d           = S_WAIT;
          end else begin
            state_d = S_HOLD;
          end
        end
        if (dn_rvalid_i) proto_err_d = 1'b1;
      end

      S_HOLD: begin
        // The lock holds even if the owner drops its request before the grant.
        dn_req_o = 1'b1;
        if (dn_gnt_i) begin
          up_gnt_o[owner_q] = 1'b1;
          state_d           = S_WAIT;
        end
        if (dn_rvalid_i) proto_err_d = 1'b1;
      end

      S_WAIT: begin
        if (dn_gnt_i) proto_err_d = 1'b1;
        if (dn_rvalid_i) begin
          up_rvalid_o[owner_q] = 1'b1;
          up_rdata_o           = dn_rdata_i;
          up_err_o             = dn_err_i;
          state_d              = S_ARB;
`ifdef DEV_PORT_ARB_FIXED_PRIO_EN
          rr_ptr_d = '0;
`else
          rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
`endif
        end
      end

      default: state_d = S_ARB;
    endcase
  end

  // Downstream request payload comes from the selected requester, zero when idle.
  assign dn_addr_o  = dn_req_o ? up_addr_i[{sel, 5'b0} +: 32]  : '0;
  assign dn_wdata_o = dn_req_o ? up_wdata_i[{sel, 5'b0} +: 32] : '0;
  assign dn_be_o    = dn_req_o ? up_be_i[{sel, 2'b0} +: 4]     : '0;
  assign dn_we_o    = dn_req_o ? up_we_i[sel]                  : 1'b0;

  // State, owner, round-robin pointer and sticky protocol-error registers.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ARB;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_dev_port_arb.sv
// tb_dev_port_arb: directed scoreboard bench for dev_port_arb (NUM_REQ=2).
// Stimulus pushes expected grants/completions into queues; a negedge monitor
// pops and compares whenever the DUT presents a grant or completion.
module tb_dev_port_arb;

  localparam int N = 2;
`ifdef DEV_PORT_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    up_req;
  logic [N*32-1:0] up_addr;
  logic [N-1:0]    up_we;
  logic [N*4-1:0]  up_be;
  logic [N*32-1:0] up_wdata;
  logic [N-1:0]    up_gnt_o;
  logic [N-1:0]    up_rvalid_o;
  logic            up_err_o;
  logic [31:0]     up_rdata_o;
  logic            dn_req_o;
  logic [31:0]     dn_addr_o;
  logic            dn_we_o;
  logic [3:0]      dn_be_o;
  logic [31:0]     dn_wdata_o;
  logic            dn_gnt;
  logic            dn_rvalid;
  logic            dn_err;
  logic [31:0]     dn_rdata;

  dev_port_arb #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_req_i(up_req), .up_addr_i(up_addr), .up_we_i(up_we),
    .up_be_i(up_be), .up_wdata_i(up_wdata),
    .up_gnt_o(up_gnt_o), .up_rvalid_o(up_rvalid_o),
    .up_err_o(up_err_o), .up_rdata_o(up_rdata_o),
    .dn_req_o(dn_req_o), .dn_addr_o(dn_addr_o), .dn_we_o(dn_we_o),
    .dn_be_o(dn_be_o), .dn_wdata_o(dn_wdata_o),
    .dn_gnt_i(dn_gnt), .dn_rvalid_i(dn_rvalid),
    .dn_err_i(dn_err), .dn_rdata_i(dn_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] mask;
    logic [31:0]  rdata;
    logic         err;
  } rv_t;

  logic [N-1:0] gnt_q[$];
  rv_t          rv_q[$];
  logic [N-1:0] mon_gnt_exp;
  rv_t          mon_rv_exp;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare whenever the DUT shows a grant or completion.
  always @(negedge clk) begin
    if (up_gnt_o != '0) begin
      if (gnt_q.size() == 0) begin
        check("unexpected_gnt", 32'(up_gnt_o), 32'd0);
      end else begin
        mon_gnt_exp = gnt_q.pop_front();
        check("gnt", 32'(up_gnt_o), 32'(mon_gnt_exp));
      end
    end
    if (up_rvalid_o != '0) begin
      if (rv_q.size() == 0) begin
        check("unexpected_rvalid", 32'(up_rvalid_o), 32'd0);
      end else begin
        mon_rv_exp = rv_q.pop_front();
        check("rvalid_mask", 32'(up_rvalid_o), 32'(mon_rv_exp.mask));
        check("rvalid_rdata", up_rdata_o, mon_rv_exp.rdata);
        check("rvalid_err", 32'(up_err_o), 32'(mon_rv_exp.err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    up_req    = '0;
    dn_gnt    = 1'b0;
    dn_rvalid = 1'b0;
    dn_err    = 1'b0;
    dn_rdata  = '0;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic we,
                         input logic [3:0] be, input logic [31:0] wd);
    up_addr[32*i +: 32]  = a;
    up_we[i]             = we;
    up_be[4*i +: 4]      = be;
    up_wdata[32*i +: 32] = wd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},    32'(up_gnt_o), 32'd0);
    check({tag, "_rvalid"}, 32'(up_rvalid_o), 32'd0);
    check({tag, "_rdata"},  up_rdata_o, 32'd0);
    check({tag, "_err"},    32'(up_err_o), 32'd0);
    check({tag, "_dn_req"}, 32'(dn_req_o), 32'd0);
    check({tag, "_dn_addr"}, dn_addr_o, 32'd0);
    check({tag, "_dn_we"},  32'(dn_we_o), 32'd0);
    check({tag, "_dn_be"},  32'(dn_be_o), 32'd0);
    check({tag, "_dn_wdata"}, dn_wdata_o, 32'd0);
    check({tag, "_rr_ptr"}, 32'(dut.rr_ptr_q), 32'd0);
    check({tag, "_owner"},  32'(dut.owner_q), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b1;
    up_addr  = '0;
    up_we    = '0;
    up_be    = '0;
    up_wdata = '0;
    idle();
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("reset");
    check("reset_proto_err", 32'(dut.proto_err_q), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // T1: single read from req0, immediate grant, completion 3 cycles later.
    set_req(0, 32'h0000_1000, 1'b0, 4'hF, 32'h0);
    up_req = 2'b01;
    dn_gnt = 1'b1;
    gnt_q.push_back(2'b01);
    #2;
    check("t1_dn_req", 32'(dn_req_o), 32'd1);
    check("t1_dn_addr", dn_addr_o, 32'h0000_1000);
    check("t1_dn_we", 32'(dn_we_o), 32'd0);
    step();
    up_req = '0;
    dn_gnt = 1'b0;
    #2 check("t1_wait_no_req", 32'(dn_req_o), 32'd0);
    step();
    step();
    dn_rvalid = 1'b1;
    dn_rdata  = 32'hDEAD_BEEF;
    rv_q.push_back('{mask: 2'b01, rdata: 32'hDEAD_BEEF, err: 1'b0});
    step();
    idle();

    // T2: both requesting continuously, grant then completion next cycle.
    do_reset();
    set_req(0, 32'h0000_0100, 1'b0, 4'hF, 32'h0);
    set_req(1, 32'h0000_0200, 1'b0, 4'hF, 32'h0);
    up_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      logic [N-1:0] exp_m;
      exp_m     = (FIXED || (i % 2 == 0)) ? 2'b01 : 2'b10;
      dn_gnt    = 1'b1;
      dn_rvalid = 1'b0;
      gnt_q.push_back(exp_m);
      step();
      dn_gnt    = 1'b0;
      dn_rvalid = 1'b1;
      dn_rdata  = 32'h0000_0A00 + 32'(i);
      rv_q.push_back('{mask: exp_m, rdata: 32'h0000_0A00 + 32'(i), err: 1'b0});
      step();
    end
    idle();
    check("t2_proto_err", 32'(dut.proto_err_q), 32'd0);

    // T3: downstream stalls; req1 locked even after req0 rises.
    set_req(1, 32'h0000_2000, 1'b0, 4'hF, 32'h0);
    set_req(0, 32'h0000_1111, 1'b0, 4'hF, 32'h0);
    up_req = 2'b10;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) up_req = 2'b11;
      #2;
      check("t3_stall_req", 32'(dn_req_o), 32'd1);
      check("t3_stall_addr", dn_addr_o, 32'h0000_2000);
      step();
    end
    dn_gnt = 1'b1;
    gnt_q.push_back(2'b10);
    #2 check("t3_gnt_addr", dn_addr_o, 32'h0000_2000);
    step();
    up_req    = '0;
    dn_gnt    = 1'b0;
    dn_rvalid = 1'b1;
    dn_rdata  = 32'h0000_2222;
    rv_q.push_back('{mask: 2'b10, rdata: 32'h0000_2222, err: 1'b0});
    step();
    idle();

    // T4: write from req1 completing with an error.
    set_req(1, 32'h0000_3000, 1'b1, 4'h3, 32'h1234_5678);
    up_req = 2'b10;
    dn_gnt = 1'b1;
    gnt_q.push_back(2'b10);
    #2;
    check("t4_dn_addr", dn_addr_o, 32'h0000_3000);
    check("t4_dn_we", 32'(dn_we_o), 32'd1);
    check("t4_dn_be", 32'(dn_be_o), 32'h3);
    check("t4_dn_wdata", dn_wdata_o, 32'h1234_5678);
    step();
    up_req   = '0;
    dn_gnt   = 1'b0;
    dn_rdata = 32'hFFFF_FFFF;
    dn_err   = 1'b1;
    #2;
    check("t4_rdata_gated", up_rdata_o, 32'd0);
    check("t4_err_gated", 32'(up_err_o), 32'd0);
    step();
    dn_rvalid = 1'b1;
    dn_err    = 1'b1;
    dn_rdata  = 32'h0;
    rv_q.push_back('{mask: 2'b10, rdata: 32'h0, err: 1'b1});
    step();
    idle();

    // T5: spurious completion while idle.
    check("t5_proto_err_before", 32'(dut.proto_err_q), 32'd0);
    dn_rvalid = 1'b1;
    dn_rdata  = 32'hAAAA_5555;
    #2 check("t5_no_rvalid", 32'(up_rvalid_o), 32'd0);
    step();
    idle();
    check("t5_proto_err_set", 32'(dut.proto_err_q), 32'd1);

    // T6: move rr_ptr off 0, then reset while a transaction waits for rvalid.
    set_req(0, 32'h0000_4000, 1'b0, 4'hF, 32'h0);
    up_req = 2'b01;
    dn_gnt = 1'b1;
    gnt_q.push_back(2'b01);
    step();
    up_req    = '0;
    dn_gnt    = 1'b0;
    dn_rvalid = 1'b1;
    dn_rdata  = 32'h0000_0077;
    rv_q.push_back('{mask: 2'b01, rdata: 32'h0000_0077, err: 1'b0});
    step();
    idle();
    check("t6_rr_ptr_moved", 32'(dut.rr_ptr_q), FIXED ? 32'd0 : 32'd1);
    set_req(1, 32'h0000_5000, 1'b0, 4'hF, 32'h0);
    up_req = 2'b10;
    dn_gnt = 1'b1;
    gnt_q.push_back(2'b10);
    step();
    up_req   = '0;
    dn_gnt   = 1'b0;
    dn_rdata = 32'h0000_0055;
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("t6_rst");
    check("t6_rst_proto_err", 32'(dut.proto_err_q), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    dn_rvalid = 1'b1;
    dn_rdata  = 32'h0000_0099;
    #2 check("t6_late_rvalid_blocked", 32'(up_rvalid_o), 32'd0);
    step();
    idle();
    check("t6_late_rvalid_flag", 32'(dut.proto_err_q), 32'd1);
    set_req(0, 32'h0000_6000, 1'b0, 4'hF, 32'h0);
    set_req(1, 32'h0000_7000, 1'b0, 4'hF, 32'h0);
    up_req = 2'b11;
    dn_gnt = 1'b1;
    gnt_q.push_back(2'b01);
    #2 check("t6_post_rst_addr", dn_addr_o, 32'h0000_6000);
    step();
    up_req    = '0;
    dn_gnt    = 1'b0;
    dn_rvalid = 1'b1;
    dn_rdata  = 32'h0000_6666;
    rv_q.push_back('{mask: 2'b01, rdata: 32'h0000_6666, err: 1'b0});
    step();
    idle();

    step();
    step();
    check("gnt_queue_drained", 32'(gnt_q.size()), 32'd0);
    check("rvalid_queue_drained", 32'(rv_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
